fir_coeff_sequencer: RTL and testbench
======================================

# fir_coeff_sequencer

Command-driven controller for the correlator FIR coefficient store and filter enables. Decodes 8-bit host command bytes (opcode in bits 7:4, operand in bits 3:0) and sequences the store: it assembles two-byte coefficient writes and sweeps zeros into every tap on clear-all. It also holds the filter run enable and pulses the accumulator clear. It sits between the host write port and the FIR tap array.

## Interface
- `NTAPS`, 16: number of taps, 2..16; tap address is 4 bits wide.
- `CW`, 16: coefficient width, fixed at 16; the high byte is sent first.
- `clk`  in  1  system clock; every register updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `we_in`  in  1  host byte strobe; one byte per high cycle.
- `din`  in  8  host byte; either a command or coefficient data, depending on state.
- `busy`  out  1  high while the block ignores host bytes (WRITE, SWEEP).
- `c_addr`  out  4  tap address to the coefficient store.
- `c_data`  out  CW  coefficient value to the store.
- `c_we`  out  1  coefficient store write strobe.
- `filt_en`  out  1  filter run enable (level).
- `acc_clr`  out  1  one-cycle accumulator clear pulse.
- `cmd_err`  out  1  sticky command error flag (see Configuration).

## Operation
- **Opcodes** (`din[7:4]`), valid only in IDLE:
  - 0000 STOP_FILTERING: `filt_en` <= 0.
  - 0001 START_FILTERING: `filt_en` <= 1.
  - 0010 CLR: `acc_clr` pulse; also clears `cmd_err`.
  - 0100 SET_COEFF: latches `din[3:0]` as the target tap.
  - 1000 CLR_ALL_COEFF: starts the zero sweep.
  - Any other opcode: no action, counts as an error.
- **FSM states:** IDLE, GET_HI, GET_LO, WRITE, SWEEP.
- **IDLE**
  - SET_COEFF with tap < NTAPS -> GET_HI.
  - SET_COEFF with tap >= NTAPS -> stays IDLE, error.
  - CLR_ALL_COEFF -> SWEEP with the address counter at 0.
  - STOP, START and CLR execute and the FSM stays in IDLE.
- **GET_HI:** the next `we_in` byte goes to `c_data[15:8]` -> GET_LO. The byte is treated as data, never decoded.
- **GET_LO:** the next `we_in` byte goes to `c_data[7:0]` -> WRITE.
  - There is no timeout: GET_HI and GET_LO wait indefinitely.
- **WRITE:** `c_we`=1 with `c_addr`=latched tap -> IDLE.
- **SWEEP:** `c_we`=1, `c_data`=0 and `c_addr`=counter each cycle. Counter increments; after address NTAPS-1 -> IDLE.
- **While busy:** `we_in` in WRITE or SWEEP is dropped and counts as an error.
- **Filtering:** `filt_en` is unaffected by coefficient traffic.

## Timing
- **Reset values:** every output is 0; the FSM is in IDLE and the counter is 0. Reset is asynchronous; asserting it mid-sweep or mid-assembly aborts immediately with no further `c_we`.
- **Registered outputs:** all outputs are registered. A byte accepted on edge T0 takes effect from cycle T0+1.
- **START/STOP:** `filt_en` changes at T0+1.
- **CLR:** `acc_clr` is high for exactly cycle T0+1.
- **SET_COEFF:** if the low byte is accepted at edge Tk, `c_we` is high for cycle Tk+1 only. `busy` is high in that same cycle. The next command is accepted at edge Tk+2.
- **CLR_ALL_COEFF** accepted at T0:
  - `c_we` and `busy` are high for cycles T0+1 .. T0+NTAPS, with `c_addr` = 0 .. NTAPS-1.
  - The next command is accepted at edge T0+NTAPS+1.
- **`cmd_err`:** sets in the cycle after the offending byte. It is cleared at T0+1 by CLR, and CLR wins over a simultaneous error.

## Configuration
- **`FIR_CMD_ERR_EN` defined:** `cmd_err` is a sticky register that sets on:
  - an illegal opcode;
  - an out-of-range tap;
  - a `we_in` while busy.
- **`FIR_CMD_ERR_EN` undefined:** `cmd_err` is tied to 0 and no error logic is built. Error conditions are still silently ignored exactly as above.

## Structure
- **Shared package `fir_pkg`:**
  - opcode constants OP_STOP, OP_START, OP_CLR, OP_SET_COEFF, OP_CLR_ALL;
  - the state encoding;
  - the tap address width constant TAP_AW = 4.
- **Sub-module:** one, `fir_tap_sweeper`, the address counter with its start/done handshake used by SWEEP. Everything else is a single FSM module.

## Test plan
- **Reset and run enable:** release reset, then send 0x10 -> `filt_en`=1 the next cycle. Send 0x00 -> `filt_en`=0. All outputs are 0 after reset.
- **Coefficient write:** send 0x45, 0x12, 0x34 with gaps of 0..3 idle cycles -> one `c_we` pulse, with `c_addr`=5 and `c_data`=0x1234, one cycle after the 0x34 strobe.
- **Clear-all:** send 0x80 -> 16 consecutive `c_we` cycles with `c_addr` 0..15 and `c_data`=0. `busy` matches `c_we`. A byte 0x10 sent mid-sweep is dropped (`filt_en` stays 0) and sets `cmd_err`.
- **Error handling:** with NTAPS=8, send 0x4A -> no state change and `cmd_err`=1. Send 0x3F -> `cmd_err` stays 1. Send 0x20 -> `acc_clr` pulse and `cmd_err`=0.
- **Reset mid-sweep:** assert `rst_n` low at sweep address 6 -> `c_we`, `busy`, `c_addr` and `filt_en` are 0 asynchronously. After release, send 0x80 -> the sweep restarts at address 0.
- **Macro-off build:** repeat the error-handling scenario without `FIR_CMD_ERR_EN` -> `cmd_err` stays 0 throughout, and all other responses are identical.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants for the FIR coefficient sequencer: opcodes, FSM encoding, tap address width.
package fir_pkg;

   localparam int TAP_AW = 4;

   localparam logic [3:0] OP_STOP      = 4'b0000;
   localparam logic [3:0] OP_START     = 4'b0001;
   localparam logic [3:0] OP_CLR       = 4'b0010;
   localparam logic [3:0] OP_SET_COEFF = 4'b0100;
   localparam logic [3:0] OP_CLR_ALL   = 4'b1000;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_GET_HI = 3'd1;
   localparam logic [2:0] ST_GET_LO = 3'd2;
   localparam logic [2:0] ST_WRITE  = 3'd3;
   localparam logic [2:0] ST_SWEEP  = 3'd4;

endpackage

// File: rtl/fir_tap_sweeper.sv
// Tap address counter for the clear-all sweep: start loads address 0, done flags the last tap.
module fir_tap_sweeper
   import fir_pkg::*;
#(
   parameter int NTAPS = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              active,
   output logic [TAP_AW-1:0] addr,
   output logic              done
);

   localparam int LAST_I = NTAPS - 1;
   localparam logic [TAP_AW-1:0] LAST = LAST_I[TAP_AW-1:0];

   assign done = active && (addr == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active <= 1'b0;
         addr   <= '0;
      end else if (start) begin
         active <= 1'b1;
         addr   <= '0;
      end else if (active) begin
         if (done) begin
            active <= 1'b0;
            addr   <= '0;
         end else begin
            addr <= addr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/fir_coeff_sequencer.sv
// Host command decoder and sequencer for the FIR coefficient store and filter enables.
// Optional sticky error flag is built only when FIR_CMD_ERR_EN is defined.
module fir_coeff_sequencer
   import fir_pkg::*;
#(
   parameter int NTAPS = 16,
   parameter int CW    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_in,
   input  logic [7:0]        din,
   output logic              busy,
   output logic [TAP_AW-1:0] c_addr,
   output logic [CW-1:0]     c_data,
   output logic              c_we,
   output logic              filt_en,
   output logic              acc_clr,
   output logic              cmd_err
);

   localparam logic [TAP_AW:0] NTAPS_W = NTAPS[TAP_AW:0];

   logic [2:0]        state;
   logic [TAP_AW-1:0] tap_q;
   logic              we_q;
   logic [3:0]        opcode;
   logic [3:0]        operand;
   logic              tap_ok;
   logic              accept;
   logic              sweep_start;
   logic              sweep_active;
   logic              sweep_done;
   logic [TAP_AW-1:0] sweep_addr;

   assign opcode      = din[7:4];
   assign operand     = din[3:0];
   assign tap_ok      = ({1'b0, operand} < NTAPS_W);
   assign accept      = we_in && (state == ST_IDLE);
   assign sweep_start = accept && (opcode == OP_CLR_ALL);

   // The store strobe and busy are the same registered bit: both cover WRITE and SWEEP.
   assign c_we   = we_q;
   assign busy   = we_q;
   assign c_addr = sweep_active ? sweep_addr : tap_q;

   fir_tap_sweeper #(
      .NTAPS (NTAPS)
   ) u_sweeper (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (sweep_start),
      .active (sweep_active),
      .addr   (sweep_addr),
      .done   (sweep_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         tap_q   <= '0;
         c_data  <= '0;
         we_q    <= 1'b0;
         filt_en <= 1'b0;
         acc_clr <= 1'b0;
      end else begin
         acc_clr <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (we_in) begin
                  case (opcode)
                     OP_STOP:  filt_en <= 1'b0;
                     OP_START: filt_en <= 1'b1;
                     OP_CLR:   acc_clr <= 1'b1;
                     OP_SET_COEFF: begin
                        if (tap_ok) begin
                           tap_q <= operand;
                           state <= ST_GET_HI;
                        end
                     end
                     OP_CLR_ALL: begin
                        c_data <= '0;
                        we_q   <= 1'b1;
                        state  <= ST_SWEEP;
                     end
                     default: ;
                  endcase
               end
            end
            ST_GET_HI: begin
               if (we_in) begin
                  c_data[CW-1 -: 8] <= din;
                  state             <= ST_GET_LO;
               end
            end
            ST_GET_LO: begin
               if (we_in) begin
                  c_data[7:0] <= din;
                  we_q        <= 1'b1;
                  state       <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               we_q  <= 1'b0;
               state <= ST_IDLE;
            end
            ST_SWEEP: begin
               if (sweep_done) begin
                  we_q  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: begin
               we_q  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef FIR_CMD_ERR_EN
   logic err_hit;
   logic clr_hit;

   assign clr_hit = accept && (opcode == OP_CLR);

   always_comb begin
      err_hit = 1'b0;
      if (we_in) begin
         if ((state == ST_WRITE) || (state == ST_SWEEP)) begin
            err_hit = 1'b1;
         end else if (state == ST_IDLE) begin
            if (opcode == OP_SET_COEFF) begin
               err_hit = !tap_ok;
            end else if (!(opcode inside {OP_STOP, OP_START, OP_CLR, OP_CLR_ALL})) begin
               err_hit = 1'b1;
            end
         end
      end
   end

   // CLR takes priority so a clear is never lost to an error on the same byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_err <= 1'b0;
      end else if (clr_hit) begin
         cmd_err <= 1'b0;
      end else if (err_hit) begin
         cmd_err <= 1'b1;
      end
   end
`else
   assign cmd_err = 1'b0;
`endif

endmodule

// File: tb/tb_fir_coeff_sequencer.sv
// Directed bench for fir_coeff_sequencer: a 16-tap instance (a) and an 8-tap instance (b).
module tb_fir_coeff_sequencer;
   import fir_pkg::*;

`ifdef FIR_CMD_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic              clk;
   logic              rst_n;
   logic              we_a, we_b;
   logic [7:0]        din_a, din_b;
   logic              busy_a, busy_b;
   logic [TAP_AW-1:0] c_addr_a, c_addr_b;
   logic [15:0]       c_data_a, c_data_b;
   logic              c_we_a, c_we_b;
   logic              filt_en_a, filt_en_b;
   logic              acc_clr_a, acc_clr_b;
   logic              cmd_err_a, cmd_err_b;

   int n_checks = 0;
   int n_fail   = 0;

   fir_coeff_sequencer #(.NTAPS(16), .CW(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .we_in(we_a), .din(din_a),
      .busy(busy_a), .c_addr(c_addr_a), .c_data(c_data_a), .c_we(c_we_a),
      .filt_en(filt_en_a), .acc_clr(acc_clr_a), .cmd_err(cmd_err_a)
   );

   fir_coeff_sequencer #(.NTAPS(8), .CW(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .we_in(we_b), .din(din_b),
      .busy(busy_b), .c_addr(c_addr_b), .c_data(c_data_b), .c_we(c_we_b),
      .filt_en(filt_en_b), .acc_clr(acc_clr_b), .cmd_err(cmd_err_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; the byte is taken on the next rising edge and the
   // task returns on the following falling edge, i.e. in the first cycle after acceptance.
   task automatic apply_stimulus(input bit to_b, input logic [7:0] b);
      if (to_b) begin
         we_b  = 1'b1;
         din_b = b;
      end else begin
         we_a  = 1'b1;
         din_a = b;
      end
      @(negedge clk);
      we_a = 1'b0;
      we_b = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      we_a  = 1'b0;
      we_b  = 1'b0;
      din_a = 8'h00;
      din_b = 8'h00;

      // Reset values
      #3;
      check_output("rst c_we",    32'(c_we_a),    0);
      check_output("rst busy",    32'(busy_a),    0);
      check_output("rst c_addr",  32'(c_addr_a),  0);
      check_output("rst c_data",  32'(c_data_a),  0);
      check_output("rst filt_en", 32'(filt_en_a), 0);
      check_output("rst acc_clr", 32'(acc_clr_a), 0);
      check_output("rst cmd_err", 32'(cmd_err_a), 0);
      idle(2);
      rst_n = 1'b1;
      idle(1);

      // Run enable
      apply_stimulus(0, 8'h10);
      check_output("start filt_en", 32'(filt_en_a), 1);
      apply_stimulus(0, 8'h00);
      check_output("stop filt_en", 32'(filt_en_a), 0);

      // Coefficient write tap 5 = 0x1234, gaps 0 and 2
      apply_stimulus(0, 8'h45);
      check_output("set busy", 32'(busy_a), 0);
      apply_stimulus(0, 8'h12);
      idle(2);
      check_output("hi no c_we", 32'(c_we_a), 0);
      apply_stimulus(0, 8'h34);
      check_output("wr c_we",   32'(c_we_a),   1);
      check_output("wr busy",   32'(busy_a),   1);
      check_output("wr c_addr", 32'(c_addr_a), 5);
      check_output("wr c_data", 32'(c_data_a), 'h1234);
      idle(1);
      check_output("wr c_we end", 32'(c_we_a), 0);
      check_output("wr busy end", 32'(busy_a), 0);

      // Coefficient write tap 15 = 0xBEEF, gaps 3 and 1
      apply_stimulus(0, 8'h4F);
      idle(3);
      apply_stimulus(0, 8'hBE);
      idle(1);
      apply_stimulus(0, 8'hEF);
      check_output("wr15 c_we",   32'(c_we_a),   1);
      check_output("wr15 c_addr", 32'(c_addr_a), 15);
      check_output("wr15 c_data", 32'(c_data_a), 'hBEEF);
      idle(1);
      check_output("wr15 c_we end", 32'(c_we_a), 0);

      // Clear-all sweep with a dropped START mid-sweep
      apply_stimulus(0, 8'h80);
      check_output("sw0 c_we",   32'(c_we_a),   1);
      check_output("sw0 busy",   32'(busy_a),   1);
      check_output("sw0 c_addr", 32'(c_addr_a), 0);
      check_output("sw0 c_data", 32'(c_data_a), 0);
      for (int i = 1; i < 16; i++) begin
         @(negedge clk);
         we_a = 1'b0;
         check_output("sw c_addr", 32'(c_addr_a), 32'(i));
         check_output("sw c_we",   32'(c_we_a),   1);
         check_output("sw busy",   32'(busy_a),   1);
         if (i == 15) check_output("sw15 c_data", 32'(c_data_a), 0);
         if (i == 4) begin
            we_a  = 1'b1;
            din_a = 8'h10;
         end
      end
      @(negedge clk);
      check_output("sw end c_we",    32'(c_we_a),    0);
      check_output("sw end busy",    32'(busy_a),    0);
      check_output("sw drop filt_en", 32'(filt_en_a), 0);
      check_output("sw drop cmd_err", 32'(cmd_err_a), 32'(ERR_EN));
      apply_stimulus(0, 8'h20);
      check_output("clr acc_clr", 32'(acc_clr_a), 1);
      check_output("clr cmd_err", 32'(cmd_err_a), 0);
      idle(1);
      check_output("clr acc_clr end", 32'(acc_clr_a), 0);

      // Error handling on the 8-tap instance
      apply_stimulus(1, 8'h4A);
      check_output("oor cmd_err", 32'(cmd_err_b), 32'(ERR_EN));
      check_output("oor busy",    32'(busy_b),    0);
      apply_stimulus(1, 8'h10);
      check_output("oor still idle", 32'(filt_en_b), 1);
      apply_stimulus(1, 8'h3F);
      check_output("illegal cmd_err", 32'(cmd_err_b), 32'(ERR_EN));
      check_output("illegal filt_en", 32'(filt_en_b), 1);
      apply_stimulus(1, 8'h20);
      check_output("b clr acc_clr", 32'(acc_clr_b), 1);
      check_output("b clr cmd_err", 32'(cmd_err_b), 0);
      check_output("b clr filt_en", 32'(filt_en_b), 1);

      // Last valid tap on the 8-tap instance, then its 8-cycle sweep
      apply_stimulus(1, 8'h47);
      apply_stimulus(1, 8'hAB);
      apply_stimulus(1, 8'hCD);
      check_output("b wr c_we",   32'(c_we_b),   1);
      check_output("b wr c_addr", 32'(c_addr_b), 7);
      check_output("b wr c_data", 32'(c_data_b), 'hABCD);
      idle(1);
      apply_stimulus(1, 8'h80);
      check_output("b sw0 c_addr", 32'(c_addr_b), 0);
      idle(7);
      check_output("b sw7 c_addr", 32'(c_addr_b), 7);
      check_output("b sw7 c_we",   32'(c_we_b),   1);
      idle(1);
      check_output("b sw end c_we",   32'(c_we_b),    0);
      check_output("b sw filt_en",    32'(filt_en_b), 1);
      check_output("b sw cmd_err",    32'(cmd_err_b), 0);

      // Asynchronous reset in the middle of a sweep
      apply_stimulus(0, 8'h10);
      check_output("pre filt_en", 32'(filt_en_a), 1);
      apply_stimulus(0, 8'h80);
      idle(6);
      check_output("pre c_addr", 32'(c_addr_a), 6);
      #2 rst_n = 1'b0;
      #1;
      check_output("arst c_we",    32'(c_we_a),    0);
      check_output("arst busy",    32'(busy_a),    0);
      check_output("arst c_addr",  32'(c_addr_a),  0);
      check_output("arst filt_en", 32'(filt_en_a), 0);
      check_output("arst b filt_en", 32'(filt_en_b), 0);
      @(negedge clk);
      idle(1);
      check_output("arst hold c_we", 32'(c_we_a), 0);
      rst_n = 1'b1;
      idle(1);
      apply_stimulus(0, 8'h80);
      check_output("resw c_addr", 32'(c_addr_a), 0);
      check_output("resw c_we",   32'(c_we_a),   1);
      idle(15);
      check_output("resw c_addr15", 32'(c_addr_a), 15);
      idle(1);
      check_output("resw end c_we", 32'(c_we_a), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
